// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button front end: FSM state encoding,
// default cycle counts and the stability-counter width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_PERIOD   = 20_000_000;

  // Counter must be able to hold the largest interval it ever measures.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_toggle_pulse_sync2.sv
// Generic two-flop synchroniser for asynchronous inputs; reset value selectable
// so the flops come up at the input's inactive level.
module sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/btn_toggle_pulse.sv
// Debounced button to single-cycle toggle pulse. Define BTN_TOGGLE_AUTOREPEAT_EN
// to emit repeat pulses while the button stays held.
module btn_toggle_pulse
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW_BTN  = 0,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_raw,
  output logic t_pulse,
  output logic en_out,
  output logic btn_level
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
`endif

  logic raw_s, btn_sync;

  // Reset the synchroniser to the raw inactive level so btn_sync starts at 0.
  sync2 #(.W(1), .RST_VAL(1'(ACTIVE_LOW_BTN != 0))) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (btn_raw),
    .q    (raw_s)
  );

  assign btn_sync = (ACTIVE_LOW_BTN != 0) ? ~raw_s : raw_s;

  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          pulse_q, pulse_d;
  logic          level_q, level_d;
  logic          en_q;
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
  logic          rep_q, rep_d;
`endif

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    level_d = level_q;
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          cnt_d   = '0;
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
          level_d = 1'b1;
          cnt_d   = '0;
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
          rep_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          cnt_d   = '0;
          state_d = RELEASE_WAIT;
        end
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
        // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
        else if (cnt_q == (rep_q ? RP_LAST : RD_LAST)) begin
          pulse_d = !pulse_q;
          cnt_d   = '0;
          rep_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          cnt_d   = '0;
          state_d = PRESSED;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      en_q    <= 1'b0;
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
      rep_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      en_q    <= 1'b1;
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign t_pulse   = pulse_q;
  assign en_out    = en_q;
  assign btn_level = level_q;

endmodule

// File: tb/tb_btn_toggle_pulse.sv
// Directed bench for btn_toggle_pulse: stimulus pushes the expected pulse cycle
// into a queue, a negedge monitor pops and compares each t_pulse it sees.
module tb_btn_toggle_pulse;
  import btn_pkg::*;

  logic clk = 1'b0;
  logic rstn, btn_raw;
  logic t_pulse, en_out, btn_level;

  int cyc  = 0;
  int vec  = 0;
  int errs = 0;
  int exp_q[$];
  logic prev_pulse = 1'b0;

  btn_toggle_pulse #(
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW_BTN  (0),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .btn_raw   (btn_raw),
    .t_pulse   (t_pulse),
    .en_out    (en_out),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic act, input logic exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: each pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (t_pulse === 1'b1) begin
      vec++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_pulse @cyc %0d: got pulse want none", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (e != cyc) begin
          errs++;
          $display("FAIL pulse_cycle: got %0d want %0d", cyc, e);
        end
      end
      chk("level_at_pulse", btn_level, 1'b1);
      chk("no_back_to_back", prev_pulse, 1'b0);
    end else if (exp_q.size() != 0 && exp_q[0] < cyc) begin
      vec++;
      errs++;
      $display("FAIL missed_pulse: got none want pulse @cyc %0d", exp_q.pop_front());
    end
    prev_pulse = t_pulse;
  end

  initial begin
    rstn    = 1'b0;
    btn_raw = 1'b1;

    // Reset held with the button pressed: nothing may come out.
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("rst_t_pulse", t_pulse, 1'b0);
      chk("rst_en_out", en_out, 1'b0);
      chk("rst_btn_level", btn_level, 1'b0);
    end
    rstn = 1'b1;
    exp_q.push_back(cyc + 7);
    chk("en_before_edge", en_out, 1'b0);
    step(1);
    chk("en_after_release", en_out, 1'b1);
    step(12);
    chk("held_level", btn_level, 1'b1);
    btn_raw = 1'b0;
    step(6);
    chk("level_before_fall", btn_level, 1'b1);
    step(1);
    chk("level_after_fall", btn_level, 1'b0);
    step(5);

    // Clean press held 20 cycles.
    btn_raw = 1'b1;
    exp_q.push_back(cyc + 7);
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
    exp_q.push_back(cyc + 17);
    exp_q.push_back(cyc + 22);
`endif
    step(20);
    chk("clean_level", btn_level, 1'b1);
    btn_raw = 1'b0;
    step(12);
    chk("clean_release", btn_level, 1'b0);

    // Bounce 1,0,1,0 then hold; only the final edge counts.
    btn_raw = 1'b1; step(1);
    btn_raw = 1'b0; step(1);
    btn_raw = 1'b1; step(1);
    btn_raw = 1'b0; step(1);
    btn_raw = 1'b1;
    exp_q.push_back(cyc + 7);
    step(8);
    chk("bounce_level", btn_level, 1'b1);

    // Two-cycle release glitch while pressed.
    btn_raw = 1'b0; step(2);
    btn_raw = 1'b1; step(6);
    chk("glitch_level", btn_level, 1'b1);
    btn_raw = 1'b0;
    step(12);
    chk("glitch_release", btn_level, 1'b0);

    // Reset while in PRESS_WAIT drops the pending press.
    btn_raw = 1'b1;
    step(3);
    rstn = 1'b0;
    #1;
    chk("midrst_idle", dut.state_q == IDLE, 1'b1);
    chk("midrst_t_pulse", t_pulse, 1'b0);
    chk("midrst_en_out", en_out, 1'b0);
    chk("midrst_level", btn_level, 1'b0);
    btn_raw = 1'b0;
    step(3);
    rstn = 1'b1;
    step(12);
    chk("midrst_still_idle", dut.state_q == IDLE, 1'b1);
    chk("midrst_level_after", btn_level, 1'b0);

    // Long hold: repeats only when auto-repeat is built in.
    btn_raw = 1'b1;
    exp_q.push_back(cyc + 7);
`ifdef BTN_TOGGLE_AUTOREPEAT_EN
    exp_q.push_back(cyc + 17);
    exp_q.push_back(cyc + 22);
    exp_q.push_back(cyc + 27);
    exp_q.push_back(cyc + 32);
    exp_q.push_back(cyc + 37);
`endif
    step(38);
    btn_raw = 1'b0;
    step(15);
    chk("hold_release", btn_level, 1'b0);

    step(2);
    while (exp_q.size() != 0) begin
      vec++;
      errs++;
      $display("FAIL missing_pulse: got none want pulse @cyc %0d", exp_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
